// File: rtl/cmd_uart_bridge_pkg.sv
// Shared types and defaults for the UART command bridge.
package cmd_uart_bridge_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int unsigned BaudDivDefault = 434;

  // Command assembler: waiting for the high byte or for the low byte.
  typedef enum logic {
    WaitHigh,
    WaitLow
  } asm_state_e;

  // Response transmitter.
  typedef enum logic {
    TxIdle,
    TxShift
  } tx_state_e;

  // Baud counters get one spare bit beyond what BaudDiv needs.
  function automatic int unsigned baud_cnt_width(input int unsigned div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/cmd_uart_bridge_rx.sv
// Serial byte receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling.
// Emits a one-cycle rx_rdy_o for a good frame or frm_err_o for a bad stop bit.
module uart_rx
  import cmd_uart_bridge_pkg::*;
#(
  parameter int unsigned BaudDiv = BaudDivDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_rdy_o,
  output logic       frm_err_o
);

  localparam int unsigned CntW = baud_cnt_width(BaudDiv);
  localparam logic [CntW-1:0] HalfLast = CntW'(BaudDiv / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(BaudDiv - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            busy_q, busy_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [CntW-1:0] sample_last;

  // Synchronize the asynchronous pin; idle-high reset avoids a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit timing and sampling; bit 0 is start, 1..8 data, 9 stop.
  always_comb begin
    busy_d      = busy_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rdy_d       = 1'b0;
    err_d       = 1'b0;
    // Start bit is sampled half a bit in so later samples land mid-bit.
    sample_last = (bit_cnt_q == 4'd0) ? HalfLast : FullLast;

    if (!busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        busy_d     = 1'b1;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    end else if (baud_cnt_q != sample_last) begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end else begin
      baud_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd0) begin
        // Start bit gone high again: glitch, drop it.
        if (rx_sync_q) begin
          busy_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end else if (bit_cnt_q == 4'd9) begin
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        if (rx_sync_q) rdy_d = 1'b1;
        else           err_d = 1'b1;
      end else begin
        shift_d = {rx_sync_q, shift_q[7:1]};
      end
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  assign rx_data_o = shift_q;
  assign rx_rdy_o  = rdy_q;
  assign frm_err_o = err_q;

endmodule

// File: rtl/cmd_uart_bridge.sv
// UART command bridge: assembles two received bytes (high first) into a 16-bit
// command with a ready flag, and serializes an 8-bit response back out.
module cmd_uart_bridge
  import cmd_uart_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned CntW = baud_cnt_width(BAUD_DIV);
  localparam logic [CntW-1:0] BitLast = CntW'(BAUD_DIV - 1);

  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;

  uart_rx #(
    .BaudDiv(BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (RX),
    .rx_data_o(rx_data),
    .rx_rdy_o (rx_rdy),
    .frm_err_o(frm_err)
  );

  asm_state_e asm_state_q, asm_state_d;
  logic [7:0] cmd_hi_q, cmd_hi_d;
  logic [7:0] cmd_lo_q, cmd_lo_d;
  logic       cmd_rdy_q, cmd_rdy_d;

  // Command assembly; setting the ready flag beats a simultaneous clear.
  always_comb begin
    asm_state_d = asm_state_q;
    cmd_hi_d    = cmd_hi_q;
    cmd_lo_d    = cmd_lo_q;
    cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;

    if (frm_err) begin
      // Resynchronize on the next byte as a high byte.
      asm_state_d = WaitHigh;
    end else if (rx_rdy) begin
      unique case (asm_state_q)
        WaitHigh: begin
          cmd_hi_d    = rx_data;
          cmd_rdy_d   = 1'b0;  // never pair an old flag with half a new command
          asm_state_d = WaitLow;
        end
        WaitLow: begin
          cmd_lo_d    = rx_data;
          cmd_rdy_d   = 1'b1;
          asm_state_d = WaitHigh;
        end
      endcase
    end
  end

  // Assembler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state_q <= WaitHigh;
      cmd_hi_q    <= '0;
      cmd_lo_q    <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      cmd_hi_q    <= cmd_hi_d;
      cmd_lo_q    <= cmd_lo_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  tx_state_e       tx_state_q, tx_state_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CntW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_done_q, tx_done_d;

  // Response shifter; TX is the shifter LSB, filled with ones behind the frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = tx_done_q;

    unique case (tx_state_q)
      TxIdle: begin
        if (trmt) begin
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_done_d  = 1'b0;
          tx_state_d = TxShift;
        end
      end
      TxShift: begin
        if (tx_baud_q != BitLast) begin
          tx_baud_d = tx_baud_q + 1'b1;
        end else begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_bit_d   = '0;
            tx_done_d  = 1'b1;
            tx_state_d = TxIdle;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
    endcase
  end

  // Transmitter state register; all-ones shifter keeps the line idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_shift_q[0];
  assign cmd     = {cmd_hi_q, cmd_lo_q};
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// Directed bench for cmd_uart_bridge at the default 434 clocks per bit.
module tb_cmd_uart_bridge;

  localparam int BAUD = 434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int n_cmp = 0;
  int n_err = 0;

  cmd_uart_bridge #(
    .BAUD_DIV(BAUD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Count rising edges of cmd_rdy.
  int   rises = 0;
  logic rdy_prev = 1'b0;
  always @(posedge clk) begin
    rdy_prev <= cmd_rdy;
    if (cmd_rdy && !rdy_prev) rises <= rises + 1;
  end

  // Remote-side receiver decoding bytes off TX.
  int         tx_frames = 0;
  logic [7:0] tx_last = 8'h00;
  initial begin
    logic [7:0] b;
    @(posedge rst_n);
    forever begin
      @(negedge TX);
      repeat (BAUD / 2) @(negedge clk);
      if (TX == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        if (TX) begin
          tx_last = b;
          tx_frames++;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cyc(BAUD);
    end
    RX = stop;
    wait_cyc(BAUD);
    RX = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  initial begin
    logic [9:0] frame;
    int         r0;
    int         f0;

    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp        = 8'h00;
    trmt        = 1'b0;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(2);

    check_eq("reset_tx", TX, 1'b1);
    check_eq("reset_cmd", cmd, 16'h0000);
    check_eq("reset_cmd_rdy", cmd_rdy, 1'b0);
    check_eq("reset_tx_done", tx_done, 1'b0);

    // Single command, then consumer clear.
    r0 = rises;
    send_cmd(16'h43F3);
    check_eq("single_cmd", cmd, 16'h43F3);
    check_eq("single_rdy", cmd_rdy, 1'b1);
    check_eq("single_rises", rises, r0 + 1);
    clr_cmd_rdy = 1'b1;
    wait_cyc(1);
    clr_cmd_rdy = 1'b0;
    check_eq("clr_rdy", cmd_rdy, 1'b0);
    check_eq("clr_keeps_cmd", cmd, 16'h43F3);

    // Response frame with an ignored second trmt while shifting.
    frame = {1'b1, 8'hA5, 1'b0};
    f0    = tx_frames;
    resp  = 8'hA5;
    trmt  = 1'b1;
    wait_cyc(1);
    trmt = 1'b0;
    for (int n = 1; n <= 10 * BAUD + 1; n++) begin
      if (n > 1) wait_cyc(1);
      if (n == 3 * BAUD + 100) begin
        resp = 8'h5A;
        trmt = 1'b1;
      end
      if (n == 3 * BAUD + 101) trmt = 1'b0;
      if ((n % BAUD) == BAUD / 2 && n < 10 * BAUD)
        check_eq($sformatf("tx_bit%0d", n / BAUD), TX, frame[n / BAUD]);
      if (n == 10 * BAUD) check_eq("tx_done_early", tx_done, 1'b0);
      if (n == 10 * BAUD + 1) begin
        check_eq("tx_done_4340", tx_done, 1'b1);
        check_eq("tx_idle_high", TX, 1'b1);
      end
    end
    wait_cyc(2 * BAUD);
    check_eq("tx_one_frame", tx_frames, f0 + 1);
    check_eq("tx_remote_byte", tx_last, 8'hA5);
    check_eq("tx_done_held", tx_done, 1'b1);

    // Framing error while waiting for a low byte forces resync to high byte.
    send_byte(8'h77, 1'b1);
    check_eq("half_cmd", cmd, 16'h77F3);
    check_eq("half_rdy", cmd_rdy, 1'b0);
    r0 = rises;
    send_byte(8'h12, 1'b0);
    wait_cyc(BAUD);
    check_eq("frm_err_cmd", cmd, 16'h77F3);
    check_eq("frm_err_rdy", cmd_rdy, 1'b0);
    send_cmd(16'h2003);
    check_eq("after_err_cmd", cmd, 16'h2003);
    check_eq("after_err_rdy", cmd_rdy, 1'b1);
    check_eq("after_err_rises", rises, r0 + 1);

    // Stale flag cleared by the next high byte.
    send_byte(8'h34, 1'b1);
    check_eq("stale_cleared", cmd_rdy, 1'b0);
    check_eq("stale_hi_cmd", cmd, 16'h3403);
    send_byte(8'h01, 1'b1);
    check_eq("stale_cmd", cmd, 16'h3401);
    check_eq("stale_rdy", cmd_rdy, 1'b1);

    // Reset during RX data bit 4.
    RX = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 4; i++) begin
      RX = ((8'h3C >> i) & 8'h01) != 8'h00;
      wait_cyc(BAUD);
    end
    RX = 1'b1;
    wait_cyc(BAUD / 2);
    rst_n = 1'b0;
    wait_cyc(3);
    check_eq("rxrst_cmd_rdy", cmd_rdy, 1'b0);
    check_eq("rxrst_cmd", cmd, 16'h0000);
    check_eq("rxrst_tx", TX, 1'b1);
    check_eq("rxrst_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    wait_cyc(10 * BAUD);

    // Reset during TX bit 6 (data bit 5 of 8'hC3 is 0).
    resp = 8'hC3;
    trmt = 1'b1;
    wait_cyc(1);
    trmt = 1'b0;
    wait_cyc(6 * BAUD + 200);
    check_eq("txrst_pre_tx", TX, 1'b0);
    rst_n = 1'b0;
    wait_cyc(2);
    check_eq("txrst_tx", TX, 1'b1);
    check_eq("txrst_tx_done", tx_done, 1'b0);
    check_eq("txrst_cmd_rdy", cmd_rdy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(11 * BAUD);

    r0 = rises;
    send_cmd(16'h43F3);
    check_eq("post_rst_cmd", cmd, 16'h43F3);
    check_eq("post_rst_rdy", cmd_rdy, 1'b1);
    check_eq("post_rst_rises", rises, r0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
